mio_arbiter: RTL and testbench

//  Shares the single mio memory port between instruction fetch and the load/store stage of the rv32i pipeline.
//  One outstanding transaction at a time; variable memory latency; response returned to the owning requester.

---
 rtl/mio_arbiter.sv | 141 ++++++++++++++
 tb/tb_mio_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mio_arbiter
//  Purpose  : Shares the mio memory port between fetch and load/store.
//  Revision : 1.0
// ============================================================================
module mio_arbiter #(
    parameter int STARVE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_vld,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_gnt,
    output logic        d_vld,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mio_req,
    output logic        mio_we,
    output logic [31:0] mio_addr,
    output logic [31:0] mio_wdata,
    output logic [3:0]  mio_wmask,
    input  logic        mio_vld,
    input  logic [31:0] mio_rdata
);

    typedef enum logic [0:0] {
        c_idle = 1'b0,
        c_busy = 1'b1
    } state_t;

    localparam logic [3:0] c_starve_max = 4'(STARVE);
    localparam logic [7:0] c_timeout    = 8'(TIMEOUT);

    state_t      r_state;
    logic        r_owner_d;
    logic [3:0]  r_starve;
    logic [7:0]  r_wd;
    logic        w_pick_f;

    // Data normally wins; fetch wins alone or once it has been starved enough.
    assign w_pick_f = f_req & (~d_req | (r_starve == c_starve_max));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_idle;
            r_owner_d <= 1'b0;
            r_starve  <= '0;
            r_wd      <= '0;
            f_gnt     <= 1'b0;
            f_vld     <= 1'b0;
            f_rdata   <= '0;
            f_err     <= 1'b0;
            d_gnt     <= 1'b0;
            d_vld     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mio_req   <= 1'b0;
            mio_we    <= 1'b0;
            mio_addr  <= '0;
            mio_wdata <= '0;
            mio_wmask <= '0;
        end else begin
            f_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            mio_req <= 1'b0;
            f_vld   <= 1'b0;
            d_vld   <= 1'b0;
            f_err   <= 1'b0;
            d_err   <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (f_req | d_req) begin
                        r_state <= c_busy;
                        r_wd    <= 8'd1;
                        mio_req <= 1'b1;
                        if (w_pick_f) begin
                            r_owner_d <= 1'b0;
                            f_gnt     <= 1'b1;
                            mio_we    <= 1'b0;
                            mio_addr  <= f_addr;
                            mio_wdata <= '0;
                            mio_wmask <= '0;
                            r_starve  <= '0;
                        end else begin
                            r_owner_d <= 1'b1;
                            d_gnt     <= 1'b1;
                            mio_we    <= d_we;
                            mio_addr  <= d_addr;
                            mio_wdata <= d_wdata;
                            mio_wmask <= d_wmask;
                            if (!f_req)
                                r_starve <= '0;
                            else if (r_starve != c_starve_max)
                                r_starve <= r_starve + 4'd1;
                        end
                    end
                end
                c_busy: begin
                    // A response on the timeout edge still counts as a normal completion.
                    if (mio_vld) begin
                        r_state <= c_idle;
                        if (r_owner_d) begin
                            d_vld   <= 1'b1;
                            d_rdata <= mio_rdata;
                        end else begin
                            f_vld   <= 1'b1;
                            f_rdata <= mio_rdata;
                        end
                    end else if (r_wd == c_timeout) begin
                        r_state <= c_idle;
                        if (r_owner_d) begin
                            d_vld   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            f_vld   <= 1'b1;
                            f_err   <= 1'b1;
                            f_rdata <= '0;
                        end
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mio_arbiter
//  Purpose  : Directed self-checking bench for mio_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_mio_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_vld, f_err;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_gnt, d_vld, d_err;
    logic [31:0] d_rdata;
    logic        mio_req, mio_we;
    logic [31:0] mio_addr, mio_wdata;
    logic [3:0]  mio_wmask;
    logic        mio_vld = 1'b0;
    logic [31:0] mio_rdata = '0;

    int total = 0;
    int bad   = 0;

    mio_arbiter #(.STARVE(4), .TIMEOUT(64)) dut (
        .clk(clk), .clr(clr),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_vld(f_vld),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_gnt(d_gnt), .d_vld(d_vld), .d_rdata(d_rdata),
        .d_err(d_err),
        .mio_req(mio_req), .mio_we(mio_we), .mio_addr(mio_addr),
        .mio_wdata(mio_wdata), .mio_wmask(mio_wmask),
        .mio_vld(mio_vld), .mio_rdata(mio_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected grant order under sustained contention: 4 data, fetch, data.
    logic exp_f [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset and idle
        tick(); tick();
        clr = 1'b0;
        tick();
        chk("rst_mio_req", {31'd0, mio_req}, 32'd0);
        chk("rst_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
        chk("rst_vld", {28'd0, f_vld, d_vld, f_err, d_err}, 32'd0);
        chk("rst_addr", mio_addr, 32'd0);
        chk("rst_frdata", f_rdata, 32'd0);

        // Single fetch, response 3 cycles after the strobe
        f_req = 1'b1; f_addr = 32'h10;
        tick();
        chk("f1_gnt", {31'd0, f_gnt}, 32'd1);
        chk("f1_mio_req", {31'd0, mio_req}, 32'd1);
        chk("f1_addr", mio_addr, 32'h10);
        chk("f1_we", {31'd0, mio_we}, 32'd0);
        f_req = 1'b0;
        tick();
        chk("f1_req_pulse", {30'd0, mio_req, f_gnt}, 32'd0);
        tick();
        mio_vld = 1'b1; mio_rdata = 32'h13;
        tick();
        mio_vld = 1'b0;
        chk("f1_vld", {29'd0, f_vld, f_err, d_vld}, 32'b100);
        chk("f1_rdata", f_rdata, 32'h13);
        tick();
        chk("f1_vld_pulse", {31'd0, f_vld}, 32'd0);
        chk("f1_rdata_hold", f_rdata, 32'h13);

        // Simultaneous requests: store first, fetch at mio_vld+2
        f_req = 1'b1; f_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
        tick();
        chk("c_gnt", {30'd0, f_gnt, d_gnt}, 32'b01);
        chk("c_we", {31'd0, mio_we}, 32'd1);
        chk("c_addr", mio_addr, 32'h100);
        chk("c_wdata", mio_wdata, 32'hDEADBEEF);
        chk("c_wmask", {28'd0, mio_wmask}, 32'hF);
        d_req = 1'b0;
        mio_vld = 1'b1; mio_rdata = 32'h55;
        tick();
        mio_vld = 1'b0;
        chk("c_dvld", {29'd0, d_vld, d_err, f_vld}, 32'b100);
        chk("c_drdata", d_rdata, 32'h55);
        chk("c_no_req", {31'd0, mio_req}, 32'd0);
        tick();
        chk("c_fgnt", {30'd0, f_gnt, mio_req}, 32'b11);
        chk("c_faddr", mio_addr, 32'h20);
        chk("c_fcmd", {mio_we, mio_wmask, mio_wdata[26:0]}, 32'd0);
        chk("c_fwdata", mio_wdata, 32'd0);
        f_req = 1'b0;
        mio_vld = 1'b1; mio_rdata = 32'h77;
        tick();
        mio_vld = 1'b0;
        chk("c_fvld", {30'd0, f_vld, d_vld}, 32'b10);
        chk("c_frdata", f_rdata, 32'h77);
        chk("c_drdata_hold", d_rdata, 32'h55);

        // Starvation: fetch held against continuous loads
        f_req = 1'b1; f_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("s%0d_gnt", i), {30'd0, f_gnt, d_gnt},
                {30'd0, exp_f[i], ~exp_f[i]});
            if (exp_f[i]) f_req = 1'b0;
            mio_vld = 1'b1; mio_rdata = 32'hA0 + 32'(i);
            tick();
            mio_vld = 1'b0;
            chk($sformatf("s%0d_vld", i), {30'd0, f_vld, d_vld},
                {30'd0, exp_f[i], ~exp_f[i]});
        end
        d_req = 1'b0;
        chk("s_drdata", d_rdata, 32'hA5);
        chk("s_frdata", f_rdata, 32'hA4);

        // Timeout on a load that never answers
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        tick();
        chk("t_gnt", {30'd0, d_gnt, mio_req}, 32'b11);
        chk("t_addr", mio_addr, 32'h200);
        d_req = 1'b0;
        repeat (63) tick();
        chk("t_before", {31'd0, d_vld}, 32'd0);
        tick();
        chk("t_abort", {28'd0, d_vld, d_err, f_vld, f_err}, 32'b1100);
        chk("t_rdata", d_rdata, 32'd0);
        mio_vld = 1'b1; mio_rdata = 32'hBAD;
        tick();
        mio_vld = 1'b0;
        chk("t_late", {28'd0, d_vld, f_vld, d_err, mio_req}, 32'd0);
        chk("t_rdata_hold", d_rdata, 32'd0);

        // Reset in the middle of a fetch
        f_req = 1'b1; f_addr = 32'h40;
        tick();
        chk("r_gnt", {30'd0, f_gnt, mio_req}, 32'b11);
        f_req = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mio_vld = 1'b1; mio_rdata = 32'h99;
        tick();
        mio_vld = 1'b0;
        chk("r_drop", {30'd0, f_vld, d_vld}, 32'd0);
        chk("r_addr", mio_addr, 32'd0);
        chk("r_frdata", f_rdata, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        chk("r_next_gnt", {30'd0, d_gnt, mio_req}, 32'b11);
        chk("r_next_addr", mio_addr, 32'h500);
        d_req = 1'b0;
        mio_vld = 1'b1; mio_rdata = 32'h1234;
        tick();
        mio_vld = 1'b0;
        chk("r_next_vld", {30'd0, d_vld, d_err}, 32'b10);
        chk("r_next_rdata", d_rdata, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
